gravador_jogadas: RTL
=====================

Name: gravador_jogadas

Overview:
- Writer-side counterpart to the game's synchronous 16x4 sequence memories.
- Captures one-hot player moves, validates them, and writes them into an internal synchronous 16x4 RAM at consecutive addresses.
- Exposes a 1-cycle-latency read port so the comparison datapath can replay the recorded sequence exactly as it reads the fixed-sequence ROMs.
- Sits between the button edge detector and the game control unit.

Parameters:
- DEPTH, 16, number of storable moves (address width 4; DEPTH must be 16).
- WIDTH, 4, width of one move (one-hot, one bit per button).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on the rising clock edge.
- limpa  input  1  synchronous clear of the write pointer; RAM contents are retained.
- jogada  input  4  player move, one-hot.
- jogada_valida  input  1  single-cycle strobe: jogada is valid this cycle.
- endereco_leitura  input  4  binary read address.
- dado_leitura  output  4  RAM word at endereco_leitura, registered.
- contagem  output  5  number of moves stored, 0..16.
- cheia  output  1  high when contagem==16.
- pronto  output  1  high in ESPERA (ready to accept a move).
- escrita_ok  output  1  one-cycle pulse after a successful write.
- erro_jogada  output  1  one-cycle pulse when a move is rejected.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to ESPERA; contagem=0.
  - cheia=0, escrita_ok=0, erro_jogada=0, dado_leitura=4'b0000.
  - RAM contents are not cleared.
  - Reset overrides every other input in the same cycle, including mid-write: a pending write is aborted and not committed.
- FSM states: ESPERA, VALIDA, ESCREVE, CHEIA.
- ESPERA:
  - pronto=1.
  - If jogada_valida=1, register jogada into jogada_reg and go to VALIDA.
  - If limpa=1 in the same cycle as jogada_valida, limpa wins: contagem=0, the strobe is ignored, and the state stays ESPERA.
- VALIDA:
  - If jogada_reg is exactly one-hot (0001/0010/0100/1000), go to ESCREVE.
  - Otherwise (0000 or two or more bits set), pulse erro_jogada for 1 cycle, leave contagem unchanged, and return to ESPERA.
- ESCREVE:
  - RAM[contagem[3:0]] <= jogada_reg and contagem <= contagem+1.
  - escrita_ok pulses on the next cycle.
  - Next state is CHEIA if the new contagem==16, else ESPERA.
- CHEIA:
  - cheia=1 and pronto=0.
  - jogada_valida pulses the same erro_jogada as a malformed move and write nothing.
  - limpa=1 sets contagem=0 and moves to ESPERA.
- Strobes outside ESPERA:
  - jogada_valida in VALIDA or ESCREVE is dropped silently; no error pulse is generated.
  - Upstream must wait for pronto before sending the next move.
- Throughput and latency:
  - One move per 3 cycles minimum (ESPERA→VALIDA→ESCREVE).
  - A strobe at edge N gives the RAM write at edge N+2, with escrita_ok high during cycle N+3.
- Read port:
  - dado_leitura <= RAM[endereco_leitura] on every edge; latency 1 cycle; independent of the FSM.
  - Same-address read and write in one cycle returns the old data (read-before-write).
  - Reads at addresses >= contagem return stale contents; the control unit must bound reads by contagem.
- Pointer limits: contagem saturates at 16. The address wraps only through limpa/reset, never by overflow.

Decomposition:
- Shared package or header holds:
  - state encodings (ESPERA=2'b00, VALIDA=2'b01, ESCREVE=2'b10, CHEIA=2'b11);
  - the WIDTH and DEPTH constants;
  - the one-hot legal-move constants 4'b0001, 4'b0010, 4'b0100, 4'b1000, shared with the ROM sequence tables.
- Sub-module ram_sync_16x4:
  - ports: clock, we, endereco_escrita, dado_escrita, endereco_leitura, dado_leitura;
  - registered read.
- The top level holds the FSM, pointer and validation.

Test Plan:
- Reset check: reset=0 for 2 cycles → contagem=0, cheia=0, pronto=1, dado_leitura=0000. Then write 0100 → escrita_ok pulses 3 cycles after the strobe; reading address 0 returns 0100 one cycle after the address is applied.
- Fill to capacity:
  - Write 16 legal moves cycling 0001,0010,0100,1000 → contagem=16, cheia=1, pronto=0.
  - A 17th strobe (1000) → erro_jogada pulse, contagem stays 16, RAM[0] is still 0001.
  - limpa → contagem=0, ESPERA.
- Illegal moves: strobes with jogada=0000, then 0110, then 1111 → three erro_jogada pulses, no escrita_ok, contagem unchanged.
- Simultaneous limpa and strobe: contagem=5, limpa=1 together with jogada_valida (0010) → contagem=0, no write, no pulse.
- Reset mid-write: assert reset=0 exactly at the ESCREVE edge → contagem=0, no escrita_ok; RAM at that address keeps its prior value.
- Read-before-write: read address 3 while 1000 is being written to address 3 (prior value 0001) → dado_leitura=0001 that cycle, 1000 on the next read.

Source files
------------

// File: rtl/gravador_jogadas_pkg.sv
// Shared constants for the move recorder: state encodings, move width/depth and
// the legal one-hot moves (the same words the fixed-sequence ROMs hold).
package gravador_jogadas_pkg;

   localparam int unsigned Width     = 4;
   localparam int unsigned Depth     = 16;
   localparam int unsigned AddrWidth = 4;

   localparam logic [AddrWidth:0] ContagemMax = 5'd16;

   localparam logic [Width-1:0] Jogada0 = 4'b0001;
   localparam logic [Width-1:0] Jogada1 = 4'b0010;
   localparam logic [Width-1:0] Jogada2 = 4'b0100;
   localparam logic [Width-1:0] Jogada3 = 4'b1000;

   typedef enum logic [1:0] {
      Espera  = 2'b00,
      Valida  = 2'b01,
      Escreve = 2'b10,
      Cheia   = 2'b11
   } estado_t;

   function automatic logic eh_jogada_legal(input logic [Width-1:0] j);
      return (j == Jogada0) || (j == Jogada1) || (j == Jogada2) || (j == Jogada3);
   endfunction

endpackage

// File: rtl/ram_sync_16x4.sv
// 16x4 synchronous RAM, one write port and one registered read port.
// A read of the address being written returns the old word.
module ram_sync_16x4
   import gravador_jogadas_pkg::*;
(
   input  logic                 clock,
   input  logic                 we,
   input  logic [AddrWidth-1:0] endereco_escrita,
   input  logic [Width-1:0]     dado_escrita,
   input  logic [AddrWidth-1:0] endereco_leitura,
   output logic [Width-1:0]     dado_leitura
);

   logic [Width-1:0] mem [Depth];
   logic [Width-1:0] dado_q;

   always_ff @(posedge clock) begin
      if (we) begin
         mem[endereco_escrita] <= dado_escrita;
      end
      dado_q <= mem[endereco_leitura];
   end

   assign dado_leitura = dado_q;

endmodule

// File: rtl/gravador_jogadas.sv
// Records validated one-hot player moves into a 16x4 RAM at consecutive addresses
// and offers a 1-cycle-latency read port for replaying the recorded sequence.
module gravador_jogadas
   import gravador_jogadas_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 limpa,
   input  logic [Width-1:0]     jogada,
   input  logic                 jogada_valida,
   input  logic [AddrWidth-1:0] endereco_leitura,
   output logic [Width-1:0]     dado_leitura,
   output logic [AddrWidth:0]   contagem,
   output logic                 cheia,
   output logic                 pronto,
   output logic                 escrita_ok,
   output logic                 erro_jogada
);

   estado_t              estado_q, estado_d;
   logic [Width-1:0]     jogada_q, jogada_d;
   logic [AddrWidth:0]   contagem_q, contagem_d;
   logic                 ok_q, ok_d;
   logic                 erro_q, erro_d;
   logic                 leitura_ok_q;
   logic                 escreve;
   logic [Width-1:0]     ram_dado;

   always_comb begin
      estado_d   = estado_q;
      jogada_d   = jogada_q;
      contagem_d = contagem_q;
      ok_d       = 1'b0;
      erro_d     = 1'b0;
      escreve    = 1'b0;
      case (estado_q)
         Espera: begin
            if (limpa) begin
               contagem_d = '0;
            end else if (jogada_valida) begin
               jogada_d = jogada;
               estado_d = Valida;
            end
         end
         Valida: begin
            if (eh_jogada_legal(jogada_q)) begin
               estado_d = Escreve;
            end else begin
               erro_d   = 1'b1;
               estado_d = Espera;
            end
         end
         Escreve: begin
            escreve = 1'b1;
            ok_d    = 1'b1;
            if (contagem_q != ContagemMax) begin
               contagem_d = contagem_q + 5'd1;
            end
            estado_d = (contagem_d == ContagemMax) ? Cheia : Espera;
         end
         Cheia: begin
            if (limpa) begin
               contagem_d = '0;
               estado_d   = Espera;
            end else if (jogada_valida) begin
               erro_d = 1'b1;
            end
         end
         default: estado_d = Espera;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q     <= Espera;
         jogada_q     <= '0;
         contagem_q   <= '0;
         ok_q         <= 1'b0;
         erro_q       <= 1'b0;
         leitura_ok_q <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         jogada_q     <= jogada_d;
         contagem_q   <= contagem_d;
         ok_q         <= ok_d;
         erro_q       <= erro_d;
         leitura_ok_q <= 1'b1;
      end
   end

   // Reset must abort an in-flight write, so the write enable is gated directly.
   ram_sync_16x4 u_ram (
      .clock            (clock),
      .we               (escreve & reset),
      .endereco_escrita (contagem_q[AddrWidth-1:0]),
      .dado_escrita     (jogada_q),
      .endereco_leitura (endereco_leitura),
      .dado_leitura     (ram_dado)
   );

   // The RAM read register has no reset; mask it for the cycle following reset.
   assign dado_leitura = leitura_ok_q ? ram_dado : '0;
   assign contagem     = contagem_q;
   assign cheia        = (estado_q == Cheia);
   assign pronto       = (estado_q == Espera);
   assign escrita_ok   = ok_q;
   assign erro_jogada  = erro_q;

endmodule
